// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_fsm : multi-cycle MIPS sequencer with memory timeout   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       Fault,
  output logic [3:0] State
);

  localparam logic [3:0] c_FETCH   = 4'd0;
  localparam logic [3:0] c_DECODE  = 4'd1;
  localparam logic [3:0] c_MEMADR  = 4'd2;
  localparam logic [3:0] c_MEMRD   = 4'd3;
  localparam logic [3:0] c_MEMWB   = 4'd4;
  localparam logic [3:0] c_MEMWR   = 4'd5;
  localparam logic [3:0] c_RTEXE   = 4'd6;
  localparam logic [3:0] c_RTWB    = 4'd7;
  localparam logic [3:0] c_BRANCH  = 4'd8;
  localparam logic [3:0] c_ADDIEXE = 4'd9;
  localparam logic [3:0] c_ANDIEXE = 4'd10;
  localparam logic [3:0] c_IWB     = 4'd11;
  localparam logic [3:0] c_JAL     = 4'd12;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;

  // Fault fires in the MEM_TIMEOUT-th consecutive stalled cycle.
  localparam logic [7:0] c_TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0] r_state;
  logic [7:0] r_tcnt;
  logic [3:0] w_next;
  logic       w_wait;
  logic       w_timeout;
  logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite, w_irwrite;
  logic       w_regwrite, w_alusrca, w_instrdone, w_fault;
  logic [1:0] w_memtoreg, w_regdst, w_alusrcb, w_aluop, w_pcsource;

  always_comb begin
    w_next        = r_state;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_instrdone   = 1'b0;
    w_fault       = 1'b0;
    w_memtoreg    = 2'b00;
    w_regdst      = 2'b00;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    w_pcsource    = 2'b00;
    w_wait        = ((r_state == c_FETCH) || (r_state == c_MEMRD) ||
                     (r_state == c_MEMWR)) && !MemReady;
    w_timeout     = w_wait && (r_tcnt == c_TMO_LAST);

    case (r_state)
      c_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = MemReady;
        w_pcwrite = MemReady;
        if (MemReady) w_next = c_DECODE;
      end
      c_DECODE: begin
        w_alusrcb = 2'b11;
        case (Opcode)
          c_OP_RTYPE:       w_next = c_RTEXE;
          c_OP_LW, c_OP_SW: w_next = c_MEMADR;
          c_OP_ADDI:        w_next = c_ADDIEXE;
          c_OP_ANDI:        w_next = c_ANDIEXE;
          c_OP_BEQ:         w_next = c_BRANCH;
          c_OP_JAL:         w_next = c_JAL;
          default: begin
            w_next  = c_FETCH;
            w_fault = 1'b1;
          end
        endcase
      end
      c_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (Opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
      end
      c_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        if (MemReady) w_next = c_MEMWB;
      end
      c_MEMWB: begin
        w_regwrite  = 1'b1;
        w_memtoreg  = 2'b01;
        w_instrdone = 1'b1;
        w_next      = c_FETCH;
      end
      c_MEMWR: begin
        w_memwrite  = 1'b1;
        w_iord      = 1'b1;
        w_instrdone = MemReady;
        if (MemReady) w_next = c_FETCH;
      end
      c_RTEXE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = c_RTWB;
      end
      c_RTWB: begin
        w_regwrite  = 1'b1;
        w_regdst    = 2'b01;
        w_instrdone = 1'b1;
        w_next      = c_FETCH;
      end
      c_ADDIEXE, c_ANDIEXE: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = (r_state == c_ANDIEXE) ? 2'b11 : 2'b00;
        w_next    = c_IWB;
      end
      c_IWB: begin
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
        w_next      = c_FETCH;
      end
      c_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
        w_instrdone   = 1'b1;
        w_next        = c_FETCH;
      end
      c_JAL: begin
        w_pcwrite   = 1'b1;
        w_pcsource  = 2'b10;
        w_regwrite  = 1'b1;
        w_regdst    = 2'b10;
        w_memtoreg  = 2'b10;
        w_instrdone = 1'b1;
        w_next      = c_FETCH;
      end
      default: w_next = c_FETCH;
    endcase

    if (w_timeout) begin
      w_fault = 1'b1;
      w_next  = c_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_FETCH;
      r_tcnt  <= 8'd0;
    end else begin
      r_state <= w_next;
      r_tcnt  <= (w_wait && !w_timeout) ? r_tcnt + 8'd1 : 8'd0;
    end
  end

  // Reset masks the FETCH decode so nothing toggles while reset_n is low.
  assign PCWrite     = reset_n & w_pcwrite;
  assign PCWriteCond = reset_n & w_pcwritecond;
  assign IorD        = reset_n & w_iord;
  assign MemRead     = reset_n & w_memread;
  assign MemWrite    = reset_n & w_memwrite;
  assign IRWrite     = reset_n & w_irwrite;
  assign RegWrite    = reset_n & w_regwrite;
  assign ALUSrcA     = reset_n & w_alusrca;
  assign InstrDone   = reset_n & w_instrdone;
  assign Fault       = reset_n & w_fault;
  assign MemtoReg    = reset_n ? w_memtoreg : 2'b00;
  assign RegDst      = reset_n ? w_regdst   : 2'b00;
  assign ALUSrcB     = reset_n ? w_alusrcb  : 2'b00;
  assign ALUOp       = reset_n ? w_aluop    : 2'b00;
  assign PCSource    = reset_n ? w_pcsource : 2'b00;
  assign State       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// Testbench for multicycle_control_fsm: directed vector table, corner sequences,
// and randomized instruction streams against an instruction-path reference model.
module tb_multicycle_control_fsm;

  localparam int C_TMO = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, ALUOp, PCSource;
  logic       RegWrite, ALUSrcA, InstrDone, Fault;
  logic [3:0] State;

  multicycle_control_fsm #(.MEM_TIMEOUT(C_TMO)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .InstrDone(InstrDone), .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemtoReg, RegDst;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       InstrDone, Fault;
    logic [3:0] State;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [7:0] strb;   // PCWrite,PCWriteCond,MemRead,MemWrite,IRWrite,RegWrite,InstrDone,Fault
    logic [1:0] aluop, regdst, m2r, pcsrc;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic out_t sample();
    out_t o;
    o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
         RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Fault, State};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h04, 6'h03};
  endfunction

  // Number of states an instruction visits with no stalls.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      6'h23:                    return 5;
      6'h2B, 6'h00, 6'h08, 6'h0C: return 4;
      6'h04, 6'h03:             return 3;
      default:                  return 2;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input logic [5:0] op, input int idx);
    if (idx == 0) return 4'd0;
    if (idx == 1) return 4'd1;
    case (op)
      6'h23:   return (idx == 2) ? 4'd2 : ((idx == 3) ? 4'd3 : 4'd4);
      6'h2B:   return (idx == 2) ? 4'd2 : 4'd5;
      6'h00:   return (idx == 2) ? 4'd6 : 4'd7;
      6'h08:   return (idx == 2) ? 4'd9 : 4'd11;
      6'h0C:   return (idx == 2) ? 4'd10 : 4'd11;
      6'h04:   return 4'd8;
      6'h03:   return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  function automatic out_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                   input logic rdy, input logic tmo);
    out_t o;
    o = '0;
    o.State = st;
    case (st)
      4'd0:  begin o.MemRead = 1; o.ALUSrcB = 2'b01; o.IRWrite = rdy; o.PCWrite = rdy; end
      4'd1:  begin o.ALUSrcB = 2'b11; o.Fault = !is_legal(op); end
      4'd2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      4'd3:  begin o.MemRead = 1; o.IorD = 1; end
      4'd4:  begin o.RegWrite = 1; o.MemtoReg = 2'b01; o.InstrDone = 1; end
      4'd5:  begin o.MemWrite = 1; o.IorD = 1; o.InstrDone = rdy; end
      4'd6:  begin o.ALUSrcA = 1; o.ALUOp = 2'b10; end
      4'd7:  begin o.RegWrite = 1; o.RegDst = 2'b01; o.InstrDone = 1; end
      4'd8:  begin o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCWriteCond = 1;
                   o.PCSource = 2'b01; o.InstrDone = 1; end
      4'd9:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      4'd10: begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.ALUOp = 2'b11; end
      4'd11: begin o.RegWrite = 1; o.InstrDone = 1; end
      4'd12: begin o.PCWrite = 1; o.PCSource = 2'b10; o.RegWrite = 1;
                   o.RegDst = 2'b10; o.MemtoReg = 2'b10; o.InstrDone = 1; end
      default: ;
    endcase
    if (tmo) o.Fault = 1'b1;
    return o;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [7];
    int k;
    ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0C, 6'h04, 6'h03};
    k = $urandom_range(0, 8);
    if (k < 7) return ops[k];
    return 6'($urandom_range(0, 63));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [5:0] op, input logic rdy);
    @(negedge clk);
    reset_n  = 1'b1;
    Opcode   = op;
    MemReady = rdy;
    #2;
  endtask

  task automatic hold_reset(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n  = 1'b0;
      Opcode   = 6'($urandom_range(0, 63));
      MemReady = 1'($urandom_range(0, 1));
      #2;
      chk(name, 32'(sample()), 32'd0);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                         input logic [7:0] strb, input logic [1:0] aluop,
                         input logic [1:0] regdst, input logic [1:0] m2r,
                         input logic [1:0] pcsrc);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.strb = strb;
    v.aluop = aluop; v.regdst = regdst; v.m2r = m2r; v.pcsrc = pcsrc;
    tbl.push_back(v);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    out_t o;
    logic [5:0] cur_op;
    int   m_idx, m_tcnt, burst;
    logic rdy, stall, tmo;
    logic [3:0] st;

    // lw
    add_vec(6'h23, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h23, 1, 4'd1,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h23, 1, 4'd2,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h23, 1, 4'd3,  8'b0010_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h23, 1, 4'd4,  8'b0000_0110, 2'b00, 2'b00, 2'b01, 2'b00);
    // R-type
    add_vec(6'h00, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h00, 1, 4'd1,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h00, 1, 4'd6,  8'b0000_0000, 2'b10, 2'b00, 2'b00, 2'b00);
    add_vec(6'h00, 1, 4'd7,  8'b0000_0110, 2'b00, 2'b01, 2'b00, 2'b00);
    // addi
    add_vec(6'h08, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h08, 1, 4'd1,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h08, 1, 4'd9,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h08, 1, 4'd11, 8'b0000_0110, 2'b00, 2'b00, 2'b00, 2'b00);
    // andi
    add_vec(6'h0C, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h0C, 1, 4'd1,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h0C, 1, 4'd10, 8'b0000_0000, 2'b11, 2'b00, 2'b00, 2'b00);
    add_vec(6'h0C, 1, 4'd11, 8'b0000_0110, 2'b00, 2'b00, 2'b00, 2'b00);
    // sw with three stall cycles in MEMWR
    add_vec(6'h2B, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h2B, 1, 4'd1,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h2B, 1, 4'd2,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h2B, 0, 4'd5,  8'b0001_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h2B, 0, 4'd5,  8'b0001_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h2B, 0, 4'd5,  8'b0001_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h2B, 1, 4'd5,  8'b0001_0010, 2'b00, 2'b00, 2'b00, 2'b00);
    // beq
    add_vec(6'h04, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h04, 1, 4'd1,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h04, 1, 4'd8,  8'b0100_0010, 2'b01, 2'b00, 2'b00, 2'b01);
    // jal
    add_vec(6'h03, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h03, 1, 4'd1,  8'b0000_0000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h03, 1, 4'd12, 8'b1000_0110, 2'b00, 2'b10, 2'b10, 2'b10);
    // illegal opcode
    add_vec(6'h3F, 1, 4'd0,  8'b1010_1000, 2'b00, 2'b00, 2'b00, 2'b00);
    add_vec(6'h3F, 1, 4'd1,  8'b0000_0001, 2'b00, 2'b00, 2'b00, 2'b00);

    hold_reset(3, "reset_outputs");

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].rdy);
      o = sample();
      chk($sformatf("vec%0d", i),
          32'({o.State, o.PCWrite, o.PCWriteCond, o.MemRead, o.MemWrite, o.IRWrite,
               o.RegWrite, o.InstrDone, o.Fault, o.ALUOp, o.RegDst, o.MemtoReg, o.PCSource}),
          32'({tbl[i].st, tbl[i].strb, tbl[i].aluop, tbl[i].regdst, tbl[i].m2r, tbl[i].pcsrc}));
    end

    // FETCH timeout: stalled cycles 1..15 quiet, 16th pulses Fault with no IRWrite.
    for (int k = 1; k <= C_TMO; k++) begin
      drive(6'h23, 1'b0);
      chk($sformatf("fetch_stall%0d", k), 32'(sample()),
          32'(exp_out(4'd0, 6'h23, 1'b0, k == C_TMO)));
    end
    drive(6'h23, 1'b1);
    chk("fetch_after_tmo", 32'(sample()), 32'(exp_out(4'd0, 6'h23, 1'b1, 1'b0)));
    drive(6'h23, 1'b1);
    chk("lw_decode", 32'(sample()), 32'(exp_out(4'd1, 6'h23, 1'b1, 1'b0)));
    drive(6'h23, 1'b1);
    chk("lw_memadr", 32'(sample()), 32'(exp_out(4'd2, 6'h23, 1'b1, 1'b0)));
    drive(6'h23, 1'b0);
    chk("memrd_stall1", 32'(sample()), 32'(exp_out(4'd3, 6'h23, 1'b0, 1'b0)));
    drive(6'h23, 1'b0);
    chk("memrd_stall2", 32'(sample()), 32'(exp_out(4'd3, 6'h23, 1'b0, 1'b0)));

    // Async reset between clock edges while stalled in MEMRD.
    #1 reset_n = 1'b0;
    #1 chk("async_rst_now", 32'(sample()), 32'd0);
    hold_reset(1, "async_rst_hold");
    drive(6'h23, 1'b1);
    chk("post_rst_fetch", 32'(sample()), 32'(exp_out(4'd0, 6'h23, 1'b1, 1'b0)));
    drive(6'h23, 1'b1);
    chk("post_rst_decode", 32'(sample()), 32'(exp_out(4'd1, 6'h23, 1'b1, 1'b0)));
    hold_reset(2, "rst_before_rand");

    // Randomized instruction stream against the path model.
    cur_op = pick_op();
    m_idx  = 0;
    m_tcnt = 0;
    burst  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else if ($urandom_range(0, 39) == 0) begin
        rdy   = 1'b0;
        burst = $urandom_range(14, 20);
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      drive(cur_op, rdy);
      st    = path_state(cur_op, m_idx);
      stall = (st == 4'd0 || st == 4'd3 || st == 4'd5) && !rdy;
      tmo   = stall && (m_tcnt + 1 == C_TMO);
      o     = sample();
      chk($sformatf("rand%0d", c), 32'(o), 32'(exp_out(st, cur_op, rdy, tmo)));
      chk("rd_wr_exclusive", 32'(o.MemRead & o.MemWrite), 32'd0);
      if (stall) begin
        m_tcnt++;
        if (tmo) begin
          m_idx  = 0;
          m_tcnt = 0;
          cur_op = pick_op();
        end
      end else begin
        m_tcnt = 0;
        m_idx++;
        if (m_idx >= path_len(cur_op)) begin
          m_idx  = 0;
          cur_op = pick_op();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for a multi-cycle version of the MIPS datapath. One shared memory serves instruction and data, and one ALU serves PC increment, address calculation and execute.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives per-cycle datapath strobes and mux selects.
- Supports the opcodes R-type, lw, sw, addi, andi, beq and jal.
- Stalls on a memory ready handshake. Flags illegal opcodes.

Parameters:
- MEM_TIMEOUT, 16, number of cycles a memory state may wait for MemReady before Fault is raised; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- Opcode  input  6  instruction register bits [31:26], valid from DECODE onward
- MemReady  input  1  memory completes the current read or write in this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  2  write-data source: 00 = ALUOut, 01 = MDR, 10 = PC
- RegDst  output  2  destination register: 00 = rt, 01 = rd, 10 = $31
- RegWrite  output  1  register file write
- ALUSrcA  output  1  ALU A input: 0 = PC, 1 = rs
- ALUSrcB  output  2  ALU B input: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  output  2  ALU operation: 00 = add, 01 = sub, 10 = funct field, 11 = and
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- InstrDone  output  1  one-cycle pulse in the final state of each instruction
- Fault  output  1  one-cycle pulse on illegal opcode or memory timeout
- State  output  4  current state, for debug

Behaviour:
- Reset: the asynchronous reset puts the state in FETCH and clears the timeout counter.
  - While reset_n is low, all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, InstrDone, Fault) are 0.
  - All selects are 0 while reset_n is low; State reads 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BRANCH=8, ADDIEXE=9, ANDIEXE=10, IWB=11, JAL=12.
  - Codes 13–15 are illegal; the next state is FETCH and all strobes are 0.
- Outputs are combinational from the state. The only Mealy terms are MemReady gating, Opcode in DECODE, and the timeout on Fault.
- Unlisted strobes are 0 in every state. Unlisted selects are 00.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH until MemReady, then goes to DECODE.
- DECODE: drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - 000000 -> RTEXE
  - 100011 or 101011 -> MEMADR
  - 001000 -> ADDIEXE
  - 001100 -> ANDIEXE
  - 000100 -> BRANCH
  - 000011 -> JAL
  - any other opcode -> FETCH, with Fault=1 for this cycle
- MEMADR: drives ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if Opcode=100011, otherwise MEMWR.
- MEMRD: drives MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: drives RegWrite=1, RegDst=00, MemtoReg=01, InstrDone=1. Next state FETCH.
- MEMWR: drives MemWrite=1, IorD=1, held until MemReady. InstrDone=MemReady. Goes to FETCH on MemReady.
- RTEXE: drives ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RTWB.
- RTWB: drives RegWrite=1, RegDst=01, MemtoReg=00, InstrDone=1. Next state FETCH.
- ADDIEXE and ANDIEXE: drive ALUSrcA=1, ALUSrcB=10, with ALUOp=00 and 11 respectively. Next state IWB.
- IWB: drives RegWrite=1, RegDst=00, MemtoReg=00, InstrDone=1. Next state FETCH.
- BRANCH: drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1. Next state FETCH.
- JAL: drives PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10, InstrDone=1. Next state FETCH.
- Latency with MemReady held at 1: lw 5, sw 4, R-type 4, addi 4, andi 4, beq 3, jal 3 cycles.
- Timeout: an 8-bit counter counts consecutive cycles in FETCH, MEMRD or MEMWR with MemReady=0. It clears on MemReady or on any state change.
  - When the count reaches MEM_TIMEOUT, Fault pulses and the next state is FETCH.
  - The aborted access does not raise IRWrite, PCWrite or RegWrite.
- MemRead and MemWrite are never both 1 in the same cycle.
- reset_n asserted mid-instruction aborts at once; no partial writeback occurs.

Test Plan:
- Reset and lw: reset_n low for 3 cycles, then Opcode=100011 with MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=01 in state 4; InstrDone in cycle 5 only.
- R-type, addi, andi: each of 000000, 001000, 001100 -> 4 cycles per instruction. ALUOp in the execute state is 10, 00 and 11 respectively. RegDst is 01, 00 and 00 respectively.
- sw with a stall: MemReady=0 for 3 cycles in MEMWR -> MemWrite held high for 4 cycles; InstrDone only in the cycle with MemReady=1; RegWrite stays 0.
- beq and jal:
  - 000100 -> PCWriteCond=1 and PCSource=01 in state 8; 3 cycles total.
  - 000011 -> PCWrite=1, RegDst=10, MemtoReg=10 in state 12.
- Faults:
  - Opcode=111111 -> Fault for 1 cycle in DECODE, then FETCH.
  - MemReady=0 held in FETCH with MEM_TIMEOUT=16 -> Fault after 16 cycles; IRWrite never asserted.
- Async reset asserted in MEMRD mid-stall -> all strobes 0 immediately; State=0; after release, the next fetch starts cleanly.
